// File: rtl/wb_pkg.sv
// Shared types and helpers for the Wishbone master.
// Ops, response codes, FSM encodings and the lane-merge helper.
package wb_pkg;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_RMW   = 2'd2,
        OP_ILL   = 2'd3
    } wb_op_t;

    typedef enum logic [1:0] {
        RSP_ACK     = 2'd0,
        RSP_ERR     = 2'd1,
        RSP_TIMEOUT = 2'd2,
        RSP_ILLEGAL = 2'd3
    } wb_rsp_t;

    localparam logic [2:0] ST_IDLE    = 3'd0;
    localparam logic [2:0] ST_RD_REQ  = 3'd1;
    localparam logic [2:0] ST_RD_WAIT = 3'd2;
    localparam logic [2:0] ST_WR_REQ  = 3'd3;
    localparam logic [2:0] ST_WR_WAIT = 3'd4;

    // Widest data bus the merge helper handles.
    localparam int WB_MAX_DW = 256;

    // Bits set in sel_mask come from new_d, the rest from old_d.
    function automatic logic [WB_MAX_DW-1:0] wb_merge(
        input logic [WB_MAX_DW-1:0] old_d,
        input logic [WB_MAX_DW-1:0] new_d,
        input logic [WB_MAX_DW-1:0] sel_mask
    );
        return (old_d & ~sel_mask) | (new_d & sel_mask);
    endfunction

endpackage

// File: rtl/wb_watchdog.sv
// Bus phase watchdog: counts idle-bus cycles of one phase.
// expired_o flags the cycle whose edge would reach TIMEOUT.
import wb_pkg::*;

module wb_watchdog #(
    parameter int TIMEOUT = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic run_i,
    output logic expired_o
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] cnt;

    // Cycle counter, cleared at every phase start.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            cnt <= '0;
        end else if (clear_i) begin
            cnt <= '0;
        end else if (run_i) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired_o = run_i && (cnt == CW'(TIMEOUT - 1));

endmodule

// File: rtl/wb_master_ctrl.sv
// Wishbone B4 initiator: single read, write or locked RMW
// per command, classic or pipelined, with a phase watchdog.
import wb_pkg::*;

module wb_master_ctrl #(
    parameter  int ADDR_WIDTH = 16,
    parameter  int DATA_WIDTH = 32,
    parameter  int GRANULE    = 8,
    parameter  int TIMEOUT    = 16,
    localparam int SEL_WIDTH  = DATA_WIDTH / GRANULE
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  cmd_valid_i,
    output logic                  cmd_ready_o,
    input  logic [1:0]            cmd_op_i,
    input  logic                  cmd_pipe_i,
    input  logic [ADDR_WIDTH-1:0] cmd_adr_i,
    input  logic [SEL_WIDTH-1:0]  cmd_sel_i,
    input  logic [DATA_WIDTH-1:0] cmd_dat_i,
    output logic                  rsp_valid_o,
    output logic [1:0]            rsp_status_o,
    output logic [DATA_WIDTH-1:0] rsp_dat_o,
    output logic                  cyc_o,
    output logic                  stb_o,
    output logic                  we_o,
    output logic [ADDR_WIDTH-1:0] adr_o,
    output logic [SEL_WIDTH-1:0]  sel_o,
    output logic [DATA_WIDTH-1:0] dat_o,
    input  logic [DATA_WIDTH-1:0] dat_i,
    input  logic                  ack_i,
    input  logic                  err_i,
    input  logic                  stall_i
);

    logic [2:0]            state;
    logic                  pipe_q;
    logic                  rmw_q;
    logic [DATA_WIDTH-1:0] wdat_q;
    logic [SEL_WIDTH-1:0]  wsel_q;
    logic [DATA_WIDTH-1:0] lane_mask;
    logic [DATA_WIDTH-1:0] merged;
    logic                  busy;
    logic                  rd_phase;
    logic                  in_req;
    logic                  bus_hit;
    logic                  to_write;
    logic                  wd_clear;
    logic                  wd_run;
    logic                  wd_expired;

    assign busy     = (state != ST_IDLE);
    assign rd_phase = (state == ST_RD_REQ) || (state == ST_RD_WAIT);
    assign in_req   = (state == ST_RD_REQ) || (state == ST_WR_REQ);
    assign bus_hit  = busy && (ack_i || err_i);
    assign to_write = rd_phase && rmw_q && ack_i && !err_i;
    assign wd_clear = (!busy && cmd_valid_i) || to_write;
    assign wd_run   = busy && !(ack_i || err_i);

    // Expand the command byte lanes into a bit mask.
    always_comb begin
        lane_mask = '0;
        for (int k = 0; k < SEL_WIDTH; k++) begin
            lane_mask[k*GRANULE +: GRANULE] = {GRANULE{wsel_q[k]}};
        end
    end

    assign merged = DATA_WIDTH'(wb_merge(WB_MAX_DW'(dat_i),
                                         WB_MAX_DW'(wdat_q),
                                         WB_MAX_DW'(lane_mask)));

    wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_wdog (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .clear_i   (wd_clear),
        .run_i     (wd_run),
        .expired_o (wd_expired)
    );

    // Command FSM driving the bus and the response port.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state        <= ST_IDLE;
            cmd_ready_o  <= 1'b1;
            rsp_valid_o  <= 1'b0;
            rsp_status_o <= RSP_ACK;
            rsp_dat_o    <= '0;
            cyc_o        <= 1'b0;
            stb_o        <= 1'b0;
            we_o         <= 1'b0;
            adr_o        <= '0;
            sel_o        <= '0;
            dat_o        <= '0;
            pipe_q       <= 1'b0;
            rmw_q        <= 1'b0;
            wdat_q       <= '0;
            wsel_q       <= '0;
        end else begin
            rsp_valid_o <= 1'b0;
            if (!busy) begin
                if (cmd_valid_i && cmd_op_i == OP_ILL) begin
                    rsp_valid_o  <= 1'b1;
                    rsp_status_o <= RSP_ILLEGAL;
                    rsp_dat_o    <= '0;
                end else if (cmd_valid_i) begin
                    cyc_o       <= 1'b1;
                    stb_o       <= 1'b1;
                    adr_o       <= cmd_adr_i;
                    pipe_q      <= cmd_pipe_i;
                    rmw_q       <= (cmd_op_i == OP_RMW);
                    wdat_q      <= cmd_dat_i;
                    wsel_q      <= cmd_sel_i;
                    cmd_ready_o <= 1'b0;
                    if (cmd_op_i == OP_WRITE) begin
                        we_o  <= 1'b1;
                        sel_o <= cmd_sel_i;
                        dat_o <= cmd_dat_i;
                        state <= ST_WR_REQ;
                    end else begin
                        we_o  <= 1'b0;
                        sel_o <= (cmd_op_i == OP_RMW) ? '1 : cmd_sel_i;
                        state <= ST_RD_REQ;
                    end
                end
            end else if (to_write) begin
                // Locked cycle: cyc_o stays high into the write.
                state     <= ST_WR_REQ;
                stb_o     <= 1'b1;
                we_o      <= 1'b1;
                dat_o     <= merged;
                rsp_dat_o <= dat_i;
            end else if (bus_hit || wd_expired) begin
                state        <= ST_IDLE;
                cmd_ready_o  <= 1'b1;
                rsp_valid_o  <= 1'b1;
                cyc_o        <= 1'b0;
                stb_o        <= 1'b0;
                we_o         <= 1'b0;
                if (!bus_hit) begin
                    rsp_status_o <= RSP_TIMEOUT;
                end else if (err_i) begin
                    rsp_status_o <= RSP_ERR;
                end else begin
                    rsp_status_o <= RSP_ACK;
                end
                if (rd_phase) begin
                    rsp_dat_o <= (bus_hit && !err_i) ? dat_i : '0;
                end else if (!rmw_q) begin
                    rsp_dat_o <= '0;
                end
            end else if (pipe_q && in_req && !stall_i) begin
                stb_o <= 1'b0;
                state <= rd_phase ? ST_RD_WAIT : ST_WR_WAIT;
            end
        end
    end

endmodule

// File: tb/tb_wb_master_ctrl.sv
// Scoreboard bench for wb_master_ctrl with a small
// register-file slave model supporting stalls and faults.
module tb_wb_master_ctrl;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0;
    logic        cmd_ready;
    logic [1:0]  cmd_op = 2'd0;
    logic        cmd_pipe = 1'b0;
    logic [15:0] cmd_adr = '0;
    logic [3:0]  cmd_sel = '0;
    logic [31:0] cmd_dat = '0;
    logic        rsp_valid_o;
    logic [1:0]  rsp_status_o;
    logic [31:0] rsp_dat_o;
    logic        cyc_o, stb_o, we_o;
    logic [15:0] adr_o;
    logic [3:0]  sel_o;
    logic [31:0] dat_o;
    logic [31:0] dat_i;
    logic        ack_i, err_i, stall_i;

    always #5 clk = ~clk;

    wb_master_ctrl #(
        .ADDR_WIDTH (16),
        .DATA_WIDTH (32),
        .GRANULE    (8),
        .TIMEOUT    (16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst_n),
        .cmd_valid_i  (cmd_valid),
        .cmd_ready_o  (cmd_ready),
        .cmd_op_i     (cmd_op),
        .cmd_pipe_i   (cmd_pipe),
        .cmd_adr_i    (cmd_adr),
        .cmd_sel_i    (cmd_sel),
        .cmd_dat_i    (cmd_dat),
        .rsp_valid_o  (rsp_valid_o),
        .rsp_status_o (rsp_status_o),
        .rsp_dat_o    (rsp_dat_o),
        .cyc_o        (cyc_o),
        .stb_o        (stb_o),
        .we_o         (we_o),
        .adr_o        (adr_o),
        .sel_o        (sel_o),
        .dat_o        (dat_o),
        .dat_i        (dat_i),
        .ack_i        (ack_i),
        .err_i        (err_i),
        .stall_i      (stall_i)
    );

    // Slave model. s_mode: 0 normal, 1 silent, 2 err on reads,
    // 3 acks reads only.
    int          s_mode = 0;
    logic        s_pipe = 1'b0;
    int          s_stall_n = 0;
    logic [31:0] mem [0:15];
    logic        ack_q = 1'b0;
    logic        err_q = 1'b0;
    int          stb_run = 0;
    logic [31:0] wlast = '0;
    logic [31:0] wmerged;
    logic        ok_s;
    logic [3:0]  idx;

    assign idx = adr_o[5:2];

    always_comb begin
        ok_s    = (s_mode == 0) || (s_mode == 3 && !we_o);
        stall_i = s_pipe && (stb_run < s_stall_n);
        ack_i   = s_pipe ? ack_q : (cyc_o & stb_o & ok_s);
        err_i   = s_pipe ? err_q : (cyc_o & stb_o & (s_mode == 2) & !we_o);
        dat_i   = mem[idx];
        wmerged = mem[idx];
        for (int k = 0; k < 4; k++) begin
            if (sel_o[k]) wmerged[8*k +: 8] = dat_o[8*k +: 8];
        end
    end

    always @(posedge clk) begin
        ack_q   <= cyc_o & stb_o & !stall_i & ok_s;
        err_q   <= cyc_o & stb_o & !stall_i & (s_mode == 2) & !we_o;
        stb_run <= (cyc_o & stb_o) ? stb_run + 1 : 0;
        if (cyc_o & stb_o & we_o & !stall_i & ok_s) begin
            mem[idx] <= wmerged;
            wlast    <= wmerged;
        end
    end

    typedef struct {
        logic [1:0]  st;
        logic [31:0] dat;
    } rsp_t;

    typedef struct {
        string       nm;
        logic [31:0] act;
        logic [31:0] exp;
    } chk_t;

    rsp_t exp_q[$];
    chk_t chk_q[$];

    int n_tests = 0;
    int n_fail = 0;
    int rsp_seen = 0;
    int rsp_edge = 0;
    int edge_n = 0;
    int stb_hi = 0;
    int we_hi = 0;
    int cyc_hi = 0;
    int cyc_rise = 0;
    int adr_chg = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    // Monitor: pops expected responses and queued checks.
    initial begin
        rsp_t        e;
        chk_t        c;
        logic        cyc_prev;
        logic [15:0] adr_prev;
        cyc_prev = 1'b0;
        adr_prev = '0;
        forever begin
            @(negedge clk);
            if (rsp_valid_o) begin
                rsp_seen++;
                rsp_edge = edge_n;
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rsp_unexpected got st=%0d dat=%h, required none",
                             rsp_status_o, rsp_dat_o);
                end else begin
                    e = exp_q.pop_front();
                    if (rsp_status_o !== e.st || rsp_dat_o !== e.dat) begin
                        n_fail++;
                        $display("FAIL rsp got st=%0d dat=%h, required st=%0d dat=%h",
                                 rsp_status_o, rsp_dat_o, e.st, e.dat);
                    end
                end
            end
            if (stb_o) stb_hi++;
            if (we_o) we_hi++;
            if (cyc_o) cyc_hi++;
            if (cyc_o && !cyc_prev) cyc_rise++;
            if (cyc_o && cyc_prev && adr_o != adr_prev) adr_chg++;
            cyc_prev = cyc_o;
            adr_prev = adr_o;
            while (chk_q.size() > 0) begin
                c = chk_q.pop_front();
                n_tests++;
                if (c.act !== c.exp) begin
                    n_fail++;
                    $display("FAIL %s got %h, required %h", c.nm, c.act, c.exp);
                end
            end
        end
    end

    task automatic check(input string nm, input logic [31:0] act,
                         input logic [31:0] exp);
        chk_q.push_back('{nm, act, exp});
    endtask

    task automatic run_cmd(input logic [1:0] op, input logic pipe,
                           input logic [15:0] adr, input logic [3:0] sel,
                           input logic [31:0] dat, input logic [1:0] est,
                           input logic [31:0] edat, output int lat);
        int n0;
        int acc;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_pipe  = pipe;
        cmd_adr   = adr;
        cmd_sel   = sel;
        cmd_dat   = dat;
        exp_q.push_back('{est, edat});
        n0 = rsp_seen;
        @(posedge clk);
        #1;
        acc = edge_n;
        cmd_valid = 1'b0;
        lat = -1;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            #1;
            if (rsp_seen != n0) begin
                lat = rsp_edge - acc;
                break;
            end
        end
        if (lat < 0) check("rsp_wait", 32'd0, 32'd1);
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout got no finish, required finish");
        $fatal(1);
    end

    // Directed stimulus.
    initial begin
        int lat;
        int s0, s1, s2, e0, r0;
        repeat (2) @(negedge clk);
        #1;
        check("rst_ready", 32'(cmd_ready), 32'd1);
        check("rst_cyc", 32'(cyc_o), 32'd0);
        check("rst_rsp_valid", 32'(rsp_valid_o), 32'd0);
        check("rst_adr", 32'(adr_o), 32'd0);
        check("rst_status", 32'(rsp_status_o), 32'd0);
        check("rst_rsp_dat", rsp_dat_o, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_ready", 32'(cmd_ready), 32'd1);
        check("post_rst_stb", 32'(stb_o), 32'd0);

        run_cmd(OP_WRITE, 1'b0, 16'h0004, 4'hF, 32'hDEADBEEF, RSP_ACK, 32'h0, lat);
        run_cmd(OP_READ, 1'b0, 16'h0004, 4'hF, 32'h0, RSP_ACK, 32'hDEADBEEF, lat);
        check("rd_latency", 32'(lat), 32'd1);
        check("rd_cyc_low", 32'(cyc_o), 32'd0);
        check("rd_ready", 32'(cmd_ready), 32'd1);

        run_cmd(OP_WRITE, 1'b0, 16'h0004, 4'hF, 32'h12345678, RSP_ACK, 32'h0, lat);
        s_pipe = 1'b1;
        s0 = stb_hi;
        run_cmd(OP_READ, 1'b1, 16'h0004, 4'hF, 32'h0, RSP_ACK, 32'h12345678, lat);
        check("prd_stb_cycles", 32'(stb_hi - s0), 32'd1);
        check("prd_latency", 32'(lat), 32'd2);

        s_stall_n = 3;
        s0 = stb_hi;
        s1 = adr_chg;
        run_cmd(OP_WRITE, 1'b1, 16'h0008, 4'hF, 32'hCAFEF00D, RSP_ACK, 32'h0, lat);
        check("pwr_stb_cycles", 32'(stb_hi - s0), 32'd4);
        check("pwr_adr_stable", 32'(adr_chg - s1), 32'd0);
        check("pwr_data", wlast, 32'hCAFEF00D);
        check("pwr_latency", 32'(lat), 32'd5);
        s_stall_n = 0;
        s_pipe = 1'b0;

        run_cmd(OP_WRITE, 1'b0, 16'h000C, 4'hF, 32'hAABBCCDD, RSP_ACK, 32'h0, lat);
        s0 = cyc_rise;
        s1 = cyc_hi;
        run_cmd(OP_RMW, 1'b0, 16'h000C, 4'h5, 32'h11223344, RSP_ACK, 32'hAABBCCDD, lat);
        check("rmw_wdata", wlast, 32'hAA22CC44);
        check("rmw_cyc_rises", 32'(cyc_rise - s0), 32'd1);
        check("rmw_cyc_cycles", 32'(cyc_hi - s1), 32'd2);
        run_cmd(OP_READ, 1'b0, 16'h000C, 4'hF, 32'h0, RSP_ACK, 32'hAA22CC44, lat);

        s_pipe = 1'b1;
        run_cmd(OP_RMW, 1'b1, 16'h000C, 4'hA, 32'h55667788, RSP_ACK, 32'hAA22CC44, lat);
        check("prmw_wdata", wlast, 32'h55227744);
        check("prmw_latency", 32'(lat), 32'd4);
        s_pipe = 1'b0;

        s_mode = 1;
        run_cmd(OP_READ, 1'b0, 16'h0010, 4'hF, 32'h0, RSP_TIMEOUT, 32'h0, lat);
        check("to_latency", 32'(lat), 32'd16);
        check("to_cyc_low", 32'(cyc_o), 32'd0);

        s_mode = 2;
        s0 = we_hi;
        run_cmd(OP_RMW, 1'b0, 16'h000C, 4'h5, 32'h99999999, RSP_ERR, 32'h0, lat);
        check("err_no_we", 32'(we_hi - s0), 32'd0);
        s_mode = 0;

        s0 = cyc_rise;
        run_cmd(OP_ILL, 1'b0, 16'h0004, 4'hF, 32'h0, RSP_ILLEGAL, 32'h0, lat);
        check("ill_no_cyc", 32'(cyc_rise - s0), 32'd0);
        check("ill_latency", 32'(lat), 32'd0);
        check("ill_ready", 32'(cmd_ready), 32'd1);

        s_mode = 3;
        r0 = rsp_seen;
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = OP_RMW;
        cmd_pipe  = 1'b0;
        cmd_adr   = 16'h000C;
        cmd_sel   = 4'h1;
        cmd_dat   = 32'h000000EE;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            #1;
            if (we_o) break;
        end
        check("mrst_in_write", 32'(we_o), 32'd1);
        e0 = edge_n;
        #1;
        rst_n = 1'b0;
        #1;
        check("mrst_cyc", 32'(cyc_o), 32'd0);
        check("mrst_stb", 32'(stb_o), 32'd0);
        check("mrst_we", 32'(we_o), 32'd0);
        s2 = edge_n;
        check("mrst_no_edge", 32'(s2), 32'(e0));
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        s_mode = 0;
        repeat (3) @(negedge clk);
        #1;
        check("mrst_ready", 32'(cmd_ready), 32'd1);
        check("mrst_no_rsp", 32'(rsp_seen), 32'(r0));

        check("exp_q_empty", 32'(exp_q.size()), 32'd0);
        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_master_ctrl.md
Name: wb_master_ctrl

Overview:
- Wishbone B4 initiator: the master end of the bus that wb_slave_register responds to.
- Accepts one command at a time from a simple valid/ready request port.
- Executes a classic or pipelined single read, single write, or read-modify-write (RMW) on the bus.
- Returns a one-cycle response carrying read data and status (ACK, ERR, TIMEOUT); a bus watchdog guarantees every command terminates.

Parameters:
- ADDR_WIDTH, 16, width of adr_o / cmd_adr_i
- DATA_WIDTH, 32, width of data buses
- GRANULE, 8, bits per select lane
- SEL_WIDTH, DATA_WIDTH/GRANULE, select width (derived, not overridable)
- TIMEOUT, 16, cycles waited per bus phase for ack_i/err_i before abort (≥2)

Ports:
- clk_i  in  1  clock, rising edge
- rst_i  in  1  reset, asynchronous, active-low
- cmd_valid_i  in  1  command present
- cmd_ready_o  out  1  command accepted when valid&ready at posedge
- cmd_op_i  in  2  OP_READ=0, OP_WRITE=1, OP_RMW=2; 3 is illegal
- cmd_pipe_i  in  1  0 = classic, 1 = pipelined handshake
- cmd_adr_i  in  ADDR_WIDTH  target address
- cmd_sel_i  in  SEL_WIDTH  byte lanes (for RMW: lanes taken from cmd_dat_i)
- cmd_dat_i  in  DATA_WIDTH  write data
- rsp_valid_o  out  1  one-cycle response strobe
- rsp_status_o  out  2  RSP_ACK=0, RSP_ERR=1, RSP_TIMEOUT=2, RSP_ILLEGAL=3
- rsp_dat_o  out  DATA_WIDTH  read data (READ/RMW), 0 otherwise
- cyc_o, stb_o, we_o  out  1 each  Wishbone control
- adr_o  out  ADDR_WIDTH  bus address
- sel_o  out  SEL_WIDTH  bus select
- dat_o  out  DATA_WIDTH  bus write data
- dat_i  in  DATA_WIDTH  bus read data
- ack_i, err_i, stall_i  in  1 each  slave responses (stall_i used only when pipelined)

Behaviour:
- All outputs registered. On reset (rst_i low, asynchronous): cyc_o=stb_o=we_o=0, adr_o/sel_o/dat_o=0, rsp_valid_o=0, rsp_status_o=0, rsp_dat_o=0, cmd_ready_o=1, FSM=IDLE, watchdog=0.
- Reset mid-transaction aborts immediately with no response.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- cmd_ready_o=1 only in IDLE.
- Accept at edge E:
  - READ/RMW -> RD_REQ, WRITE -> WR_REQ.
  - From edge E: cyc_o=stb_o=1, adr_o=cmd_adr_i.
  - sel_o=cmd_sel_i, except RMW where sel_o is all ones.
  - we_o=1 for WRITE; dat_o=cmd_dat_i for WRITE.
  - Illegal op: no bus activity; rsp_valid_o=1 after E with RSP_ILLEGAL.
- Classic, *_REQ: stb_o held until ack_i or err_i is sampled high. *_WAIT is unused.
- Pipelined, *_REQ: the request is issued at the first edge with stall_i=0. That edge drops stb_o; cyc_o stays high and the FSM moves to *_WAIT. If ack_i/err_i is sampled on the same edge, the phase completes directly.
- ack_i/err_i are ignored while cyc_o=0. If both are high on one edge, err wins.
- Read-phase ACK: rsp_dat_o <= dat_i captured at the same edge.
- Completion of READ/WRITE at edge C:
  - cyc_o=stb_o=we_o=0 from C.
  - rsp_valid_o=1 for the single cycle after C.
  - FSM=IDLE, so cmd_ready_o=1 in the same cycle as rsp_valid_o.
  - Minimum latency with a zero-wait slave: E -> C = 1 cycle.
- RMW:
  - On read ACK: cyc_o stays high (locked cycle); next edge enters WR_REQ with we_o=1, stb_o=1.
  - Write data: dat_o lane k = cmd_dat_i lane k if cmd_sel_i[k], else read-data lane k.
  - Read ERR/timeout: write phase skipped; response status is ERR/TIMEOUT, rsp_dat_o=0.
  - Final response reports the write-phase status and the read data.
- Watchdog:
  - Counter clears at each phase start and counts each cycle in RD_*/WR_* without ack/err.
  - When it reaches TIMEOUT: cyc_o=stb_o=we_o=0, RSP_TIMEOUT, FSM returns to IDLE.
  - In pipelined mode the count spans stall and wait time together.
- adr_o/sel_o/dat_o hold their last value between transactions.

Decomposition:
- wb_pkg holds:
  - wb_op_t (OP_READ/OP_WRITE/OP_RMW)
  - wb_rsp_t (RSP_ACK/ERR/TIMEOUT/ILLEGAL)
  - FSM state enum
  - byte-lane merge function wb_merge(old, new, sel)
- Sub-module wb_watchdog (TIMEOUT param; clear_i, run_i, expired_o) is natural and is reused by future bus blocks.

Test Plan:
- Classic READ adr 0x0004, sel 0xF against wb_slave_register preloaded 0xDEADBEEF -> one rsp_valid_o pulse, RSP_ACK, rsp_dat_o=0xDEADBEEF, cyc_o low after ACK edge.
- Classic WRITE 0x12345678 sel 0xF, then pipelined READ same address -> RSP_ACK both; read returns 0x12345678; stb_o high exactly one cycle in the pipelined read.
- Pipelined WRITE with stall_i held high 3 cycles -> stb_o high 4 cycles, adr_o stable, single RSP_ACK.
- RMW: register 0xAABBCCDD, cmd_dat_i 0x11223344, cmd_sel_i 0x5 -> bus write 0xAA22CC44, rsp_dat_o=0xAABBCCDD, cyc_o continuous across both phases.
- Slave never responds, TIMEOUT=16 -> RSP_TIMEOUT 16 cycles after phase start, cyc_o=0; err_i forced high in an RMW read -> RSP_ERR, no we_o pulse; op=3 -> RSP_ILLEGAL, cyc_o never asserted.
- rst_i pulled low mid-RMW write phase -> cyc_o/stb_o/we_o drop without a clock edge, no rsp_valid_o, cmd_ready_o=1 after release.
